clock_period_monitor: RTL and testbench
=======================================

# clock_period_monitor

Measures the period of a divided clock, counted in cycles of the system clock. It sits directly downstream of the programmable clock divider and treats the divider output as an asynchronous data signal. It synchronizes that signal, detects its rising edges and reports each full period through a valid/ack handshake. It also flags stalls, where no edge arrives within a timeout, and overruns, where a result is lost because the previous one was not acknowledged.

## Interface
- CNT_W, 16: width of the period counter and of `Period`.
- TIMEOUT, 1000: count value at which a measurement is abandoned. Must satisfy 4 ≤ TIMEOUT ≤ 2^CNT_W−1.

- Clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Div_in  in  1  divided clock under test (divider `Clock_out`); asynchronous to `Clock`.
- Restart  in  1  synchronous abort; the consumer pulses it after changing divider `Sel`.
- Ack  in  1  consumer acknowledges the current `Period`.
- Period  out  CNT_W  last accepted period, in `Clock` cycles.
- Valid  out  1  `Period` holds an unacknowledged result.
- Overrun  out  1  sticky; a result was dropped while `Valid` was high.
- Stalled  out  1  timeout occurred since the last rising edge.
- Busy  out  1  FSM is in MEASURE.

## Operation
- Synchronizer: `s1<=Div_in`, `s2<=s1`, `s3<=s2`.
- Edge detect: `rise = s2 & ~s3` (combinational).
- Counter `cnt`, CNT_W bits.
- FSM has two states:
  - IDLE (reset state, `Busy`=0): on `rise`, set `cnt<=1`, clear `Stalled`, go to MEASURE.
  - MEASURE (`Busy`=1):
    - On `rise`, complete a result and set `cnt<=1`; stay in MEASURE.
    - Otherwise, if `cnt==TIMEOUT`, set `Stalled<=1`, `cnt<=0`, go to IDLE. The partial count is discarded and `Valid`/`Period` are untouched.
    - Otherwise, `cnt<=cnt+1`.
- Priority at any edge: Reset > Restart > `rise` > timeout > increment.
- Result completion, with `Period` taking the value of `cnt` before the edge:
  - `Valid`=0: `Period<=cnt`, `Valid<=1`.
  - `Valid`=1 and `Ack`=1 on the same edge: `Period<=cnt`, `Valid` stays 1, no overrun.
  - `Valid`=1 and `Ack`=0: `Period` is held (oldest result kept) and `Overrun<=1`.
- Ack without completion: `Valid<=0`; `Period` is held. Ack while `Valid`=0 has no effect.
- `Overrun` is cleared only by Restart or Reset. Ack does not clear it.
- Restart: `Valid`, `Overrun`, `Stalled`, `cnt` go to 0 and the FSM goes to IDLE. `Period` is held. Synchronizer flops are not cleared.
- Reset (asynchronous): `s1..s3`, `cnt`, `Period`, `Valid`, `Overrun`, `Stalled`, `Busy` all 0; FSM in IDLE.
- No wrap-around: TIMEOUT ≤ 2^CNT_W−1 guarantees `cnt` never overflows.

## Timing
- If `Div_in` is first sampled high at edge k, `rise` is high between edges k+1 and k+2, and the FSM acts on it at edge k+2.
- Edge-to-action latency is 2 `Clock` cycles, fixed, so it cancels out of period measurements.
- A `Div_in` square wave of period P cycles gives `Period`=P exactly.
- `Div_in` must hold each level for ≥2 `Clock` cycles, so the minimum measurable `Period` is 4. Narrower pulses may be missed; this is undefined, not an error.
- First result: `Valid` rises at the action edge of the second `rise` after reset or Restart, giving roughly 2P+2 cycles of latency.
- Stall detection: `Stalled` rises TIMEOUT cycles after the action edge of the last `rise`.
- All outputs are registered, with no combinational path from inputs to outputs.
- Consumer handshake: the consumer may sample `Period` on any cycle `Valid`=1, and `Period` is stable until the edge on which it is acked.

## Test plan
- Reset mid-measurement: assert Reset asynchronously with `cnt`=5 in MEASURE → all outputs 0 before the next `Clock` edge; the first `Valid` after release follows two rising edges.
- Square wave, 4 high / 4 low: `Valid`=1 with `Period`=8, rising 2 cycles after the second `Div_in` rise. Pulse `Ack` → `Valid`=0 next edge. The next result is again 8.
- Overrun: period-8 input for three periods with no `Ack` → `Period` stays at the first value 8 and `Overrun`=1. Then `Ack` → `Valid`=0 while `Overrun` stays 1. Then Restart → `Overrun`=0.
- Ack coincident with completion: input alternates periods 8 and 12; hold `Ack`=1 on the completion edge → `Valid` stays 1, `Period`=12, `Overrun`=0.
- Timeout, TIMEOUT=20: one rise, then `Div_in` held low → `Stalled`=1 and `Busy`=0 exactly 20 cycles after the rise action edge, with `Valid` unchanged. The next rise → `Stalled`=0, `Busy`=1; a further rise 8 cycles later → `Period`=8.
- Restart mid-period: with `cnt`=3 → FSM in IDLE, `Valid`=0, `Period` held. The following two rises, 16 cycles apart → `Period`=16.

Source files
------------

// File: rtl/clock_period_monitor.sv
`default_nettype none
// ============================================================================
// Module   : clock_period_monitor
// Function : Measures the period of an asynchronous divided clock in system
//            clock cycles, with valid/ack handshake, stall and overrun flags.
// Revision : 1.0
// ============================================================================
module clock_period_monitor #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Div_in,
    input  logic             Restart,
    input  logic             Ack,
    output logic [CNT_W-1:0] Period,
    output logic             Valid,
    output logic             Overrun,
    output logic             Stalled,
    output logic             Busy
);

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_s1;
    logic               r_s2;
    logic               r_s3;
    logic               w_rise;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   w_period_next;
    logic               r_valid;
    logic               w_valid_next;
    logic               r_overrun;
    logic               w_overrun_next;
    logic               r_stalled;
    logic               w_stalled_next;
    logic               w_complete;

    // Three-stage synchronizer; the third stage only feeds edge detection.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= Div_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_period  <= w_period_next;
            r_valid   <= w_valid_next;
            r_overrun <= w_overrun_next;
            r_stalled <= w_stalled_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_period_next  = r_period;
        w_valid_next   = r_valid;
        w_overrun_next = r_overrun;
        w_stalled_next = r_stalled;
        w_complete     = 1'b0;

        if (Restart) begin
            w_state_next   = S_IDLE;
            w_cnt_next     = '0;
            w_valid_next   = 1'b0;
            w_overrun_next = 1'b0;
            w_stalled_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rise) begin
                        w_cnt_next     = c_one;
                        w_stalled_next = 1'b0;
                        w_state_next   = S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (w_rise) begin
                        w_complete = 1'b1;
                        w_cnt_next = c_one;
                    end else if (r_cnt == c_timeout) begin
                        // Partial count is dropped; the held result is left alone.
                        w_stalled_next = 1'b1;
                        w_cnt_next     = '0;
                        w_state_next   = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + c_one;
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase

            // An unacknowledged result is kept; the newer one is dropped.
            if (w_complete) begin
                if (!r_valid) begin
                    w_period_next = r_cnt;
                    w_valid_next  = 1'b1;
                end else if (Ack) begin
                    w_period_next = r_cnt;
                end else begin
                    w_overrun_next = 1'b1;
                end
            end else if (Ack) begin
                w_valid_next = 1'b0;
            end
        end
    end

    assign Period  = r_period;
    assign Valid   = r_valid;
    assign Overrun = r_overrun;
    assign Stalled = r_stalled;
    assign Busy    = (r_state == S_MEASURE);

endmodule
`default_nettype wire

// File: tb/tb_clock_period_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_clock_period_monitor
// Function : Directed bench for clock_period_monitor with a cycle-count model.
// Revision : 1.0
// ============================================================================
module tb_clock_period_monitor;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 20;

    logic             Clock   = 1'b0;
    logic             Reset   = 1'b0;
    logic             Div_in  = 1'b0;
    logic             Restart = 1'b0;
    logic             Ack     = 1'b0;
    logic [CNT_W-1:0] Period;
    logic             Valid;
    logic             Overrun;
    logic             Stalled;
    logic             Busy;

    int tests = 0;
    int fails = 0;

    clock_period_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Div_in  (Div_in),
        .Restart (Restart),
        .Ack     (Ack),
        .Period  (Period),
        .Valid   (Valid),
        .Overrun (Overrun),
        .Stalled (Stalled),
        .Busy    (Busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a rise acts two edges after Div_in is first sampled high, and
    // every result is the edge-count distance between consecutive actions.
    int cyc = 0;
    int m_last = 0;
    bit m_busy = 0, m_valid = 0, m_overrun = 0, m_stalled = 0;
    int m_period = 0;
    bit d1 = 0, d2 = 0, d3 = 0;

    always @(posedge Clock or posedge Reset) begin : b_model
        bit rise, done, nb, nv, no, ns;
        int np, nl, n;
        if (Reset) begin
            m_busy <= 0; m_valid <= 0; m_overrun <= 0; m_stalled <= 0;
            m_period <= 0; d1 <= 0; d2 <= 0; d3 <= 0;
        end else begin
            n = cyc + 1;
            nb = m_busy; nv = m_valid; no = m_overrun; ns = m_stalled;
            np = m_period; nl = m_last;
            rise = d2 && !d3;
            done = 0;
            if (Restart) begin
                nb = 0; nv = 0; no = 0; ns = 0;
            end else begin
                if (rise) begin
                    if (m_busy) begin
                        done = 1;
                        if (!m_valid) begin
                            np = n - m_last; nv = 1;
                        end else if (Ack) begin
                            np = n - m_last;
                        end else begin
                            no = 1;
                        end
                    end else begin
                        nb = 1; ns = 0;
                    end
                    nl = n;
                end else if (m_busy && (n - m_last) == TIMEOUT) begin
                    ns = 1; nb = 0;
                end
                if (!done && Ack) nv = 0;
            end
            cyc <= n;
            m_busy <= nb; m_valid <= nv; m_overrun <= no; m_stalled <= ns;
            m_period <= np; m_last <= nl;
            d3 <= d2; d2 <= d1; d1 <= Div_in;
        end
    end

    always @(negedge Clock) begin
        chk("model Period",  32'(Period),  32'(m_period));
        chk("model Valid",   32'(Valid),   32'(m_valid));
        chk("model Overrun", 32'(Overrun), 32'(m_overrun));
        chk("model Stalled", 32'(Stalled), 32'(m_stalled));
        chk("model Busy",    32'(Busy),    32'(m_busy));
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge Clock);
    endtask

    task automatic run_wave(input int hi, input int lo, input int periods);
        repeat (periods) begin
            Div_in = 1'b1; tick(hi);
            Div_in = 1'b0; tick(lo);
        end
    endtask

    task automatic pulse_restart();
        Restart = 1'b1; tick(); Restart = 1'b0;
    endtask

    task automatic pulse_ack();
        Ack = 1'b1; tick(); Ack = 1'b0;
    endtask

    initial begin : b_stim
        int k, q, seen;
        #1 Reset = 1'b1;
        tick(3);
        Reset = 1'b0;
        chk("reset Valid",   32'(Valid),   0);
        chk("reset Period",  32'(Period),  0);
        chk("reset Busy",    32'(Busy),    0);
        chk("reset Overrun", 32'(Overrun), 0);
        chk("reset Stalled", 32'(Stalled), 0);
        tick(2);

        // Async reset with cnt = 5 in MEASURE
        Div_in = 1'b1; tick(4);
        Div_in = 1'b0; tick(3);
        chk("pre-reset Busy", 32'(Busy), 1);
        #2 Reset = 1'b1;
        #1;
        chk("async reset outputs", {Period, Valid, Overrun, Stalled, Busy}, 0);
        tick();
        Reset = 1'b0;
        tick(2);

        // 4 high / 4 low square wave
        k = cyc + 1;
        run_wave(4, 4, 1);
        Div_in = 1'b1;
        tick(2);
        chk("sq Valid before", 32'(Valid), 0);
        tick();
        chk("sq latency cycle", 32'(cyc), 32'(k + 10));
        chk("sq Valid", 32'(Valid), 1);
        chk("sq Period", 32'(Period), 8);
        tick();
        Div_in = 1'b0; tick(3);
        pulse_ack();
        chk("sq ack Valid", 32'(Valid), 0);
        run_wave(4, 4, 1);
        chk("sq 2nd Valid", 32'(Valid), 1);
        chk("sq 2nd Period", 32'(Period), 8);

        // Overrun: periods 8, 8, 12 without Ack
        pulse_restart();
        chk("rst Valid", 32'(Valid), 0);
        chk("rst Period held", 32'(Period), 8);
        run_wave(4, 4, 2);
        run_wave(6, 6, 2);
        chk("ovr Period held", 32'(Period), 8);
        chk("ovr Overrun", 32'(Overrun), 1);
        chk("ovr Valid", 32'(Valid), 1);
        pulse_ack();
        chk("ovr ack Valid", 32'(Valid), 0);
        chk("ovr ack Overrun", 32'(Overrun), 1);
        pulse_restart();
        chk("ovr restart Overrun", 32'(Overrun), 0);

        // Ack on the completion edge, periods 8 then 12
        run_wave(4, 4, 1);
        run_wave(6, 6, 1);
        Div_in = 1'b1;
        tick(2);
        pulse_ack();
        chk("coinc Valid", 32'(Valid), 1);
        chk("coinc Period", 32'(Period), 12);
        chk("coinc Overrun", 32'(Overrun), 0);
        tick(3);
        Div_in = 1'b0; tick(6);

        // Timeout
        pulse_restart();
        run_wave(4, 4, 1);
        Div_in = 1'b1;
        q = cyc + 1;
        tick(4);
        Div_in = 1'b0;
        seen = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (Stalled === 1'b1) begin
                seen = cyc;
                break;
            end
        end
        chk("stall cycle", 32'(seen), 32'(q + 22));
        chk("stall Busy", 32'(Busy), 0);
        chk("stall Valid", 32'(Valid), 1);
        chk("stall Period", 32'(Period), 8);
        pulse_ack();
        Div_in = 1'b1;
        q = cyc + 1;
        tick(3);
        chk("unstall Stalled", 32'(Stalled), 0);
        chk("unstall Busy", 32'(Busy), 1);
        tick();
        Div_in = 1'b0; tick(4);
        Div_in = 1'b1; tick(4);
        Div_in = 1'b0; tick(4);
        chk("post-stall Valid", 32'(Valid), 1);
        chk("post-stall Period", 32'(Period), 8);

        // Restart with cnt = 3
        Div_in = 1'b1;
        tick(5);
        pulse_restart();
        chk("mid rst Busy", 32'(Busy), 0);
        chk("mid rst Valid", 32'(Valid), 0);
        chk("mid rst Overrun", 32'(Overrun), 0);
        chk("mid rst Period", 32'(Period), 8);
        Div_in = 1'b0; tick(4);
        run_wave(8, 8, 1);
        Div_in = 1'b1;
        tick(3);
        chk("p16 Valid", 32'(Valid), 1);
        chk("p16 Period", 32'(Period), 16);
        Div_in = 1'b0; tick(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
